// File: rtl/pipe_ctrl_hazard.sv
// Pipeline control carrier for a 5-stage RISC-V core: ID/EX, EX/MEM, MEM/WB control registers,
// hazard stall/flush and stall counting. Define PIPE_FORWARD_EN to enable EX/MEM and MEM/WB forwarding.
module pipe_ctrl_hazard #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_alusrc,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic [1:0]        id_aluop,
  input  logic              id_branch,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_br_taken,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              ex_alusrc,
  output logic [1:0]        ex_aluop,
  output logic              ex_branch,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              alusrc;
    logic              memtoreg;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic [1:0]        aluop;
    logic              branch;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic              memtoreg;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic [REG_AW-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic [REG_AW-1:0] rd;
  } memwb_t;

  idex_t            idex_d, idex_q;
  exmem_t           exmem_d, exmem_q;
  memwb_t           memwb_d, memwb_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  logic ex_hit, mem_hit, load_use, stall, hold;

  always_comb begin
    ex_hit   = (idex_q.rd != '0) && ((idex_q.rd == id_rs1) || (idex_q.rd == id_rs2));
    mem_hit  = (exmem_q.rd != '0) && ((exmem_q.rd == id_rs1) || (exmem_q.rd == id_rs2));
    load_use = idex_q.memread && ex_hit;
`ifdef PIPE_FORWARD_EN
    stall    = load_use;
`else
    stall    = load_use || (idex_q.regwrite && ex_hit) || (exmem_q.regwrite && mem_hit);
`endif
    // A taken branch squashes the stalled instruction, so flush wins over stall.
    hold       = stall && !ex_br_taken;
    pc_we      = !hold;
    ifid_we    = !hold;
    ifid_flush = ex_br_taken;
  end

  always_comb begin
    idex_d = '0;
    if (!stall && !ex_br_taken) begin
      idex_d.alusrc   = id_alusrc;
      idex_d.memtoreg = id_memtoreg;
      idex_d.regwrite = id_regwrite;
      idex_d.memread  = id_memread;
      idex_d.memwrite = id_memwrite;
      idex_d.aluop    = id_aluop;
      idex_d.branch   = id_branch;
      idex_d.rs1      = id_rs1;
      idex_d.rs2      = id_rs2;
      idex_d.rd       = id_rd;
    end
    exmem_d.memtoreg = idex_q.memtoreg;
    exmem_d.regwrite = idex_q.regwrite;
    exmem_d.memread  = idex_q.memread;
    exmem_d.memwrite = idex_q.memwrite;
    exmem_d.rd       = idex_q.rd;
    memwb_d.regwrite = exmem_q.regwrite;
    memwb_d.memtoreg = exmem_q.memtoreg;
    memwb_d.rd       = exmem_q.rd;
    cnt_d = cnt_q;
    if (hold && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
`ifdef PIPE_FORWARD_EN
    // EX/MEM holds the younger result, so it is checked first.
    if (exmem_q.regwrite && (exmem_q.rd != '0) && (exmem_q.rd == idex_q.rs1)) begin
      fwd_a = 2'b10;
    end else if (memwb_q.regwrite && (memwb_q.rd != '0) && (memwb_q.rd == idex_q.rs1)) begin
      fwd_a = 2'b01;
    end
    if (exmem_q.regwrite && (exmem_q.rd != '0) && (exmem_q.rd == idex_q.rs2)) begin
      fwd_b = 2'b10;
    end else if (memwb_q.regwrite && (memwb_q.rd != '0) && (memwb_q.rd == idex_q.rs2)) begin
      fwd_b = 2'b01;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      cnt_q   <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_alusrc    = idex_q.alusrc;
  assign ex_aluop     = idex_q.aluop;
  assign ex_branch    = idex_q.branch;
  assign ex_rs1       = idex_q.rs1;
  assign ex_rs2       = idex_q.rs2;
  assign mem_memread  = exmem_q.memread;
  assign mem_memwrite = exmem_q.memwrite;
  assign wb_regwrite  = memwb_q.regwrite;
  assign wb_memtoreg  = memwb_q.memtoreg;
  assign wb_rd        = memwb_q.rd;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Directed bench for pipe_ctrl_hazard: vector table for in-order flow and flushes, plus hand
// sequences for load-use, flush-over-stall, forwarding, x0, counter saturation and async reset.
module tb_pipe_ctrl_hazard;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

`ifdef PIPE_FORWARD_EN
  localparam int unsigned LuStalls = 1;
  localparam logic [1:0]  FwdWb    = 2'b01;
`else
  localparam int unsigned LuStalls = 2;
  localparam logic [1:0]  FwdWb    = 2'b00;
`endif

  // {alusrc, memtoreg, regwrite, memread, memwrite, aluop[1:0], branch}
  localparam logic [7:0] CNop  = 8'b0_0_0_0_0_00_0;
  localparam logic [7:0] CLw   = 8'b1_1_1_1_0_00_0;
  localparam logic [7:0] CSw   = 8'b1_0_0_0_1_00_0;
  localparam logic [7:0] CAdd  = 8'b0_0_1_0_0_10_0;
  localparam logic [7:0] CAddi = 8'b1_0_1_0_0_10_0;
  localparam logic [7:0] CBeq  = 8'b0_0_0_0_0_01_1;

  logic clk, rst_n;
  logic id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch;
  logic [1:0] id_aluop;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic ex_br_taken;
  logic pc_we, ifid_we, ifid_flush, ex_alusrc, ex_branch;
  logic [1:0] ex_aluop, fwd_a, fwd_b;
  logic [AW-1:0] ex_rs1, ex_rs2, wb_rd;
  logic mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg;
  logic [CW-1:0] stall_cnt;

  pipe_ctrl_hazard #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_aluop(id_aluop),
    .id_branch(id_branch), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_br_taken(ex_br_taken), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .ex_branch(ex_branch),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    ctl;
    logic [AW-1:0] rs1, rs2, rd;
    logic          br;
    logic [2:0]    e_if;   // pc_we, ifid_we, ifid_flush
    logic [3:0]    e_ex;   // alusrc, aluop, branch
    logic [AW-1:0] e_rs1, e_rs2;
    logic [1:0]    e_mem;  // memread, memwrite
    logic [1:0]    e_wb;   // regwrite, memtoreg
    logic [AW-1:0] e_wrd;
  } vec_t;

  vec_t tbl [9];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] c, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic [AW-1:0] rd, input logic br);
    {id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_aluop, id_branch} = c;
    id_rs1 = r1;
    id_rs2 = r2;
    id_rd = rd;
    ex_br_taken = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(CNop, 0, 0, 0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] act_v, exp_v;
    int exp_cnt;

    //        ctl    rs1 rs2 rd br  if      ex       ers1 ers2 mem    wb     wrd
    tbl[0] = '{CLw,   2,  0,  1, 0, 3'b110, 4'b0000,  0,  0, 2'b00, 2'b00,  0};
    tbl[1] = '{CSw,   3,  4,  0, 0, 3'b110, 4'b1000,  2,  0, 2'b00, 2'b00,  0};
    tbl[2] = '{CAdd,  8,  9,  7, 0, 3'b110, 4'b1000,  3,  4, 2'b10, 2'b00,  0};
    tbl[3] = '{CBeq, 10, 11,  0, 0, 3'b110, 4'b0100,  8,  9, 2'b01, 2'b11,  1};
    tbl[4] = '{CAddi,13,  0, 12, 1, 3'b111, 4'b0011, 10, 11, 2'b00, 2'b00,  0};
    tbl[5] = '{CAdd, 15, 16, 14, 0, 3'b110, 4'b0000,  0,  0, 2'b00, 2'b10,  7};
    tbl[6] = '{CAddi,18,  0, 17, 1, 3'b111, 4'b0100, 15, 16, 2'b00, 2'b00,  0};
    tbl[7] = '{CAdd, 20, 21, 19, 0, 3'b110, 4'b0000,  0,  0, 2'b00, 2'b00,  0};
    tbl[8] = '{CNop,  0,  0,  0, 0, 3'b110, 4'b0100, 20, 21, 2'b00, 2'b10, 14};

    drive(CNop, 0, 0, 0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("reset_state", {pc_we, ifid_we, ifid_flush, ex_aluop, wb_regwrite, fwd_a, fwd_b, stall_cnt},
        {3'b110, 2'b00, 1'b0, 2'b00, 2'b00, 4'h0});
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].ctl, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].br);
      @(negedge clk);
      act_v = {pc_we, ifid_we, ifid_flush, ex_alusrc, ex_aluop, ex_branch, ex_rs1, ex_rs2,
               mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg, wb_rd, fwd_a, fwd_b, stall_cnt};
      exp_v = {tbl[i].e_if, tbl[i].e_ex, tbl[i].e_rs1, tbl[i].e_rs2, tbl[i].e_mem, tbl[i].e_wb,
               tbl[i].e_wrd, 8'h00};
      chk($sformatf("vec%0d", i), 64'(act_v), 64'(exp_v));
      tick();
    end

    // Load-use: lw x5 then add rs1=x5.
    do_reset();
    drive(CLw, 0, 0, 5, 1'b0);
    tick();
    drive(CAdd, 5, 0, 6, 1'b0);
    @(negedge clk);
    chk("lu_stall", {pc_we, ifid_we, ifid_flush}, 3'b000);
    tick();
    chk("lu_bubble", {ex_alusrc, ex_aluop, ex_branch, ex_rs1}, '0);
    chk("lu_cnt1", 64'(stall_cnt), 1);
`ifndef PIPE_FORWARD_EN
    chk("lu_stall2", {pc_we, ifid_we}, 2'b00);
    tick();
`endif
    chk("lu_release", {pc_we, ifid_we}, 2'b11);
    tick();
    drive(CNop, 0, 0, 0, 1'b0);
    #1;
    chk("lu_ex_rs1", 64'(ex_rs1), 5);
    chk("lu_fwd_a", 64'(fwd_a), 64'(FwdWb));
    chk("lu_cnt", 64'(stall_cnt), 64'(LuStalls));

    // Taken branch with load-use pending: flush only.
    do_reset();
    drive(CLw, 0, 0, 5, 1'b0);
    tick();
    drive(CAdd, 5, 0, 6, 1'b1);
    @(negedge clk);
    chk("br_flush", {pc_we, ifid_we, ifid_flush}, 3'b111);
    tick();
    drive(CNop, 0, 0, 0, 1'b0);
    #1;
    chk("br_bubble", {ex_alusrc, ex_aluop, ex_branch, ex_rs1, ex_rs2}, '0);
    chk("br_mem_lw", 64'(mem_memread), 1);
    chk("br_cnt", 64'(stall_cnt), 0);

    // add x3 then sub x4, x3, x3.
    do_reset();
    drive(CAdd, 1, 2, 3, 1'b0);
    tick();
    drive(CAdd, 3, 3, 4, 1'b0);
`ifdef PIPE_FORWARD_EN
    @(negedge clk);
    chk("fw_nostall", 64'(pc_we), 1);
    tick();
    drive(CNop, 0, 0, 0, 1'b0);
    #1;
    chk("fw_sel", {fwd_a, fwd_b}, 4'b1010);
    chk("fw_cnt", 64'(stall_cnt), 0);
`else
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      chk($sformatf("nf_stall%0d", s), 64'(pc_we), 0);
      tick();
    end
    @(negedge clk);
    chk("nf_release", 64'(pc_we), 1);
    tick();
    drive(CNop, 0, 0, 0, 1'b0);
    #1;
    chk("nf_ex_rs", {ex_rs1, ex_rs2}, {5'd3, 5'd3});
    chk("nf_sel", {fwd_a, fwd_b}, 4'b0000);
    chk("nf_cnt", 64'(stall_cnt), 2);
`endif

    // x0 destination never hazards or forwards.
    do_reset();
    drive(CAddi, 1, 0, 0, 1'b0);
    tick();
    drive(CAdd, 0, 0, 8, 1'b0);
    @(negedge clk);
    chk("x0_nostall", 64'(pc_we), 1);
    tick();
    drive(CNop, 0, 0, 0, 1'b0);
    @(negedge clk);
    chk("x0_fwd", {fwd_a, fwd_b, pc_we}, 5'b00001);
    chk("x0_cnt", 64'(stall_cnt), 0);
    tick();

    // Repeated load-use pairs drive the counter into saturation.
    do_reset();
    for (int it = 0; it < 20; it++) begin
      drive(CLw, 0, 0, 5, 1'b0);
      @(negedge clk);
      chk("sat_lw", 64'(pc_we), 1);
      tick();
      drive(CAdd, 5, 0, 0, 1'b0);
      for (int s = 0; s < int'(LuStalls); s++) begin
        @(negedge clk);
        chk("sat_stall", 64'(pc_we), 0);
        tick();
      end
      @(negedge clk);
      chk("sat_go", 64'(pc_we), 1);
      tick();
      exp_cnt = (it + 1) * int'(LuStalls);
      if (exp_cnt > 15) exp_cnt = 15;
      chk($sformatf("sat_cnt%0d", it), 64'(stall_cnt), 64'(exp_cnt));
    end

    // Async reset asserted mid-stall, checked before the next edge.
    drive(CLw, 0, 0, 5, 1'b0);
    tick();
    drive(CAdd, 5, 0, 6, 1'b0);
    @(negedge clk);
    chk("pre_rst_stall", 64'(pc_we), 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {pc_we, ifid_we, ifid_flush, ex_alusrc, ex_aluop, ex_branch, ex_rs1,
                      mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg, wb_rd, stall_cnt},
        {3'b110, 4'b0000, 5'd0, 2'b00, 2'b00, 5'd0, 4'h0});
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_free", {pc_we, ifid_we, stall_cnt}, {2'b11, 4'h0});
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
